// File: rtl/i2s_source_switch_if.sv
// Request handshake between host/button logic and the I2S source switch.
interface i2s_source_switch_if #(
  parameter int SELW = 2
);
  logic [SELW-1:0] req_sel;
  logic            req_valid;
  logic            req_ready;
  logic            req_err;

  modport master (output req_sel, output req_valid, input req_ready, input req_err);
  modport slave  (input req_sel, input req_valid, output req_ready, output req_err);
endinterface

// File: rtl/i2s_source_switch.sv
// Frame-aligned I2S source switch: mute on LRCK boundaries, change select, settle, unmute.
// Optional DEWILLE_AUTOMUTE_EN: loss of LRCK while idle mutes and re-settles the same source.
module i2s_source_switch #(
  parameter int NSRC        = 4,
  parameter int SELW        = 2,
  parameter int MUTE_FRAMES = 8,
  parameter int LOSS_CYCLES = 4096
) (
  input  logic                clk,
  input  logic                rst,
  i2s_source_switch_if.slave  req,
  input  logic [NSRC-1:0]     lrck_src,
  output logic [SELW-1:0]     active_sel,
  output logic                mute,
  output logic                lock,
  output logic                busy
);

  localparam int              WDW      = $clog2(LOSS_CYCLES + 1);
  localparam int              NPAD     = 1 << SELW;
  localparam logic [WDW-1:0]  WD_MAX   = WDW'(LOSS_CYCLES);
  localparam logic [7:0]      CNT_END  = 8'(MUTE_FRAMES);
  localparam logic [SELW:0]   NSRC_LIM = (SELW+1)'(NSRC);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    SWITCH = 2'd2,
    SETTLE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [NSRC-1:0] sync1_q, sync2_q, dly_q, rise_s;
  logic [NPAD-1:0] rise_pad_s;
  logic            rise_act_s, accept_s, bad_sel_s, wd_hit_s;
  logic [SELW-1:0] sel_q, sel_d, tgt_q, tgt_d;
  logic            mute_q, mute_d, lock_q, lock_d;
  logic            busy_q, busy_d, ready_q, ready_d, err_q, err_d;
  logic [7:0]      cnt_q, cnt_d, cnt_inc_s;
  logic [WDW-1:0]  wd_q, wd_d, wd_inc_s;

  // Rise detect on synchronized LRCK and request decode
  always_comb begin
    rise_s                = sync2_q & ~dly_q;
    rise_pad_s            = '0;
    rise_pad_s[NSRC-1:0]  = rise_s;
    rise_act_s            = rise_pad_s[sel_q];
    accept_s              = req.req_valid & ready_q;
    bad_sel_s             = ({1'b0, req.req_sel} >= NSRC_LIM);
    cnt_inc_s             = cnt_q + 8'd1;
    wd_inc_s              = wd_q + WDW'(1);
  end

  // Next-state logic for watchdog, sequencer and registered outputs
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    tgt_d   = tgt_q;
    mute_d  = mute_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;

    // A rise on the same cycle as expiry wins and keeps lock
    if (rise_act_s) begin
      wd_d     = '0;
      lock_d   = 1'b1;
      wd_hit_s = 1'b0;
    end else if (wd_q == WD_MAX) begin
      wd_d     = wd_q;
      lock_d   = 1'b0;
      wd_hit_s = 1'b1;
    end else begin
      wd_d     = wd_inc_s;
      lock_d   = (wd_inc_s == WD_MAX) ? 1'b0 : lock_q;
      wd_hit_s = (wd_inc_s == WD_MAX);
    end

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          if (bad_sel_s) begin
            err_d = 1'b1;
          end else if (req.req_sel == sel_q) begin
            state_d = IDLE;
          end else begin
            tgt_d   = req.req_sel;
            state_d = DRAIN;
          end
        end
`ifdef DEWILLE_AUTOMUTE_EN
        else if (!lock_q) begin
          mute_d  = 1'b1;
          cnt_d   = 8'd0;
          state_d = SETTLE;
        end
`endif
        else begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        // mute is still low until the first frame edge after acceptance
        if (!lock_q) begin
          mute_d  = 1'b1;
          state_d = SWITCH;
        end else if (rise_act_s) begin
          if (!mute_q) begin
            mute_d = 1'b1;
            cnt_d  = 8'd0;
          end else if (cnt_inc_s == CNT_END) begin
            cnt_d   = cnt_inc_s;
            state_d = SWITCH;
          end else begin
            cnt_d = cnt_inc_s;
          end
        end else begin
          state_d = DRAIN;
        end
      end
      SWITCH: begin
        sel_d   = tgt_q;
        cnt_d   = 8'd0;
        wd_d    = '0;
        lock_d  = 1'b0;
        state_d = SETTLE;
      end
      SETTLE: begin
        if (rise_act_s) begin
          cnt_d = cnt_inc_s;
          if (cnt_inc_s == CNT_END) begin
            mute_d  = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = SETTLE;
          end
        end else if (wd_hit_s) begin
          cnt_d = 8'd0;
        end else begin
          state_d = SETTLE;
        end
      end
      default: begin
        mute_d  = 1'b1;
        state_d = SETTLE;
      end
    endcase

    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
  end

  // State, synchronizers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SETTLE;
      sync1_q <= '0;
      sync2_q <= '0;
      dly_q   <= '0;
      sel_q   <= '0;
      tgt_q   <= '0;
      mute_q  <= 1'b1;
      lock_q  <= 1'b0;
      busy_q  <= 1'b1;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      sync1_q <= lrck_src;
      sync2_q <= sync1_q;
      dly_q   <= sync2_q;
      sel_q   <= sel_d;
      tgt_q   <= tgt_d;
      mute_q  <= mute_d;
      lock_q  <= lock_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
    end
  end

  assign active_sel    = sel_q;
  assign mute          = mute_q;
  assign lock          = lock_q;
  assign busy          = busy_q;
  assign req.req_ready = ready_q;
  assign req.req_err   = err_q;

endmodule

// File: tb/tb_i2s_source_switch.sv
// Directed bench for i2s_source_switch: 3 sources at 512 clk/frame, switch, dead source, loss, reset.
module tb_i2s_source_switch;
  localparam int NSRC = 3;
  localparam int SELW = 2;
  localparam int MF   = 8;
  localparam int LOSS = 4096;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NSRC-1:0] lrck = '0;
  logic [NSRC-1:0] en = '0;
  logic [SELW-1:0] active_sel;
  logic            mute, lock, busy;
  int              rise_cnt [NSRC] = '{default: 0};
  int              errors = 0;
  int              checks = 0;

  i2s_source_switch_if #(.SELW(SELW)) req_if ();

  i2s_source_switch #(
    .NSRC(NSRC), .SELW(SELW), .MUTE_FRAMES(MF), .LOSS_CYCLES(LOSS)
  ) dut (
    .clk(clk), .rst(rst), .req(req_if.slave), .lrck_src(lrck),
    .active_sel(active_sel), .mute(mute), .lock(lock), .busy(busy)
  );

  always #5 clk = ~clk;

  // LRCK generator: 64-clk ticks, each source toggles every 4 ticks with its own phase
  initial begin
    int p;
    p = 0;
    #3;
    forever begin
      #640;
      for (int i = 0; i < NSRC; i++) begin
        if (en[i] && ((p % 4) == i)) begin
          lrck[i] = ~lrck[i];
          if (lrck[i]) rise_cnt[i] = rise_cnt[i] + 1;
        end
      end
      p = p + 1;
    end
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_rises(input int src, input int n, input string tag);
    int start;
    int budget;
    start  = rise_cnt[src];
    budget = n * 520 + 64;
    while (((rise_cnt[src] - start) < n) && (budget > 0)) begin
      @(negedge clk);
      budget = budget - 1;
    end
    if ((rise_cnt[src] - start) < n)
      chk_val({tag, "_timeout"}, 32'(rise_cnt[src] - start), 32'(n));
  endtask

  task automatic request(input logic [SELW-1:0] s);
    req_if.req_sel   = s;
    req_if.req_valid = 1'b1;
    @(negedge clk);
    req_if.req_valid = 1'b0;
  endtask

  initial begin
    req_if.req_sel   = '0;
    req_if.req_valid = 1'b0;
    wait_clk(3);
    chk_val("rst_mute",  32'(mute), 32'd1);
    chk_val("rst_lock",  32'(lock), 32'd0);
    chk_val("rst_busy",  32'(busy), 32'd1);
    chk_val("rst_ready", 32'(req_if.req_ready), 32'd0);
    chk_val("rst_err",   32'(req_if.req_err), 32'd0);
    chk_val("rst_sel",   32'(active_sel), 32'd0);
    rst   = 1'b0;
    en[0] = 1'b1;

    // Initial settle on src0
    wait_rises(0, 1, "t1_r1");
    wait_clk(4);
    chk_val("t1_lock", 32'(lock), 32'd1);
    chk_val("t1_mute_r1", 32'(mute), 32'd1);
    wait_rises(0, 6, "t1_r7");
    wait_clk(4);
    chk_val("t1_mute_r7", 32'(mute), 32'd1);
    wait_rises(0, 1, "t1_r8");
    chk_val("t1_mute_edge8", 32'(mute), 32'd1);
    wait_clk(4);
    chk_val("t1_unmute", 32'(mute), 32'd0);
    chk_val("t1_ready", 32'(req_if.req_ready), 32'd1);
    chk_val("t1_busy", 32'(busy), 32'd0);

    // Invalid and duplicate requests
    en[2] = 1'b1;
    wait_rises(0, 1, "t3_sync");
    wait_clk(10);
    request(2'd3);
    chk_val("t3_err_pulse", 32'(req_if.req_err), 32'd1);
    chk_val("t3_err_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk_val("t3_err_single", 32'(req_if.req_err), 32'd0);
    chk_val("t3_err_sel", 32'(active_sel), 32'd0);
    request(2'd0);
    chk_val("t3_dup_busy", 32'(busy), 32'd0);
    chk_val("t3_dup_mute", 32'(mute), 32'd0);
    chk_val("t3_dup_err", 32'(req_if.req_err), 32'd0);
    chk_val("t3_dup_ready", 32'(req_if.req_ready), 32'd1);

    // Normal switch src0 -> src2
    wait_rises(0, 1, "t2_sync");
    wait_clk(10);
    request(2'd2);
    chk_val("t2_busy", 32'(busy), 32'd1);
    chk_val("t2_ready", 32'(req_if.req_ready), 32'd0);
    chk_val("t2_mute_pre", 32'(mute), 32'd0);
    wait_rises(0, 1, "t2_drain_r0");
    wait_clk(4);
    chk_val("t2_mute_drain", 32'(mute), 32'd1);
    wait_rises(0, 7, "t2_drain_r7");
    wait_clk(4);
    chk_val("t2_sel_r7", 32'(active_sel), 32'd0);
    wait_rises(0, 1, "t2_drain_r8");
    wait_clk(4);
    chk_val("t2_sel_r8", 32'(active_sel), 32'd2);
    chk_val("t2_lock_sw", 32'(lock), 32'd0);
    wait_rises(2, 7, "t2_settle_r7");
    wait_clk(4);
    chk_val("t2_mute_s7", 32'(mute), 32'd1);
    wait_rises(2, 1, "t2_settle_r8");
    wait_clk(4);
    chk_val("t2_unmute", 32'(mute), 32'd0);
    chk_val("t2_lock", 32'(lock), 32'd1);
    chk_val("t2_ready_end", 32'(req_if.req_ready), 32'd1);

    // Switch to dead src1
    wait_rises(2, 1, "t4_sync");
    wait_clk(10);
    request(2'd1);
    chk_val("t4_busy", 32'(busy), 32'd1);
    wait_rises(2, 9, "t4_drain");
    wait_clk(4);
    chk_val("t4_sel", 32'(active_sel), 32'd1);
    chk_val("t4_mute", 32'(mute), 32'd1);
    wait_clk(5000);
    chk_val("t4_hold_mute", 32'(mute), 32'd1);
    chk_val("t4_hold_lock", 32'(lock), 32'd0);
    chk_val("t4_hold_busy", 32'(busy), 32'd1);
    en[1] = 1'b1;
    wait_rises(1, 7, "t4_r7");
    wait_clk(4);
    chk_val("t4_mute_r7", 32'(mute), 32'd1);
    wait_rises(1, 1, "t4_r8");
    wait_clk(4);
    chk_val("t4_unmute", 32'(mute), 32'd0);
    chk_val("t4_lock", 32'(lock), 32'd1);

    // LRCK loss while idle on src1
    wait_rises(1, 1, "t5_last");
    en[1] = 1'b0;
    wait_clk(4080);
    chk_val("t5_lock_hold", 32'(lock), 32'd1);
    wait_clk(30);
    chk_val("t5_lock_lost", 32'(lock), 32'd0);
`ifdef DEWILLE_AUTOMUTE_EN
    chk_val("t5_automute", 32'(mute), 32'd1);
    chk_val("t5_auto_busy", 32'(busy), 32'd1);
    en[1] = 1'b1;
    wait_rises(1, 7, "t5_r7");
    wait_clk(4);
    chk_val("t5_mute_r7", 32'(mute), 32'd1);
    wait_rises(1, 1, "t5_r8");
    wait_clk(4);
    chk_val("t5_unmute", 32'(mute), 32'd0);
    chk_val("t5_busy_end", 32'(busy), 32'd0);
`else
    chk_val("t5_no_mute", 32'(mute), 32'd0);
    chk_val("t5_no_busy", 32'(busy), 32'd0);
    en[1] = 1'b1;
    wait_rises(1, 1, "t5_r1");
    wait_clk(4);
    chk_val("t5_relock", 32'(lock), 32'd1);
    chk_val("t5_mute_end", 32'(mute), 32'd0);
`endif

    // Async reset in the middle of DRAIN
    wait_rises(1, 1, "t6_sync");
    wait_clk(10);
    request(2'd0);
    wait_rises(1, 1, "t6_drain");
    wait_clk(4);
    chk_val("t6_drain_mute", 32'(mute), 32'd1);
    chk_val("t6_drain_sel", 32'(active_sel), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk_val("t6_rst_mute", 32'(mute), 32'd1);
    chk_val("t6_rst_lock", 32'(lock), 32'd0);
    chk_val("t6_rst_busy", 32'(busy), 32'd1);
    chk_val("t6_rst_ready", 32'(req_if.req_ready), 32'd0);
    chk_val("t6_rst_sel", 32'(active_sel), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_rises(0, 8, "t6_settle");
    wait_clk(4);
    chk_val("t6_unmute", 32'(mute), 32'd0);
    chk_val("t6_sel_end", 32'(active_sel), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
